// File: rtl/program_loader_if.sv
// Byte-stream + memory-write bundle between the pad-side input logic, the
// loader and program_memory's byte write port.
// Latency: none (wires only). Backpressure: byte_ready from the loader gates byte_valid.
//
// Signals
//   byte_valid / byte_in / byte_ready : valid-ready byte stream into the loader
//   wrEn / writeAdd / writeData       : memory byte write port out of the loader
// Modports
//   master : stream producer / memory side (drives the stream, observes writes)
//   slave  : the loader (accepts the stream, drives the write port)
interface program_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 7
);
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_in;
    logic                  byte_ready;
    logic                  wrEn;
    logic [ADD_WIDTH-1:0]  writeAdd;
    logic [DATA_WIDTH-1:0] writeData;

    modport master (
        output byte_valid,
        output byte_in,
        input  byte_ready,
        input  wrEn,
        input  writeAdd,
        input  writeData
    );

    modport slave (
        input  byte_valid,
        input  byte_in,
        output byte_ready,
        output wrEn,
        output writeAdd,
        output writeData
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed byte stream (header, payload, optional checksum) into program memory.
// Latency: a payload byte accepted at edge k is on wrEn/writeAdd/writeData right after edge k.
// Backpressure: byte_ready is high only in HDR/DATA/CSUM; the producer holds the byte until accepted.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_start   : 1-cycle pulse, starts a new frame (honoured in IDLE/DONE only)
//   bus (slave)  : byte_valid/byte_in/byte_ready stream, wrEn/writeAdd/writeData memory port
//   cpu_hold     : CPU stall while loading (and after a checksum error)
//   load_done    : frame complete, level until next load_start
//   load_err     : checksum mismatch, level until next load_start
// Build option
//   LOADER_CHECKSUM_EN : adds the CSUM state and running-XOR check; without it
//                        DATA goes straight to DONE and load_err is constant 0.
module program_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err
);

    // Counter is one bit wider than the address so a full-memory frame
    // (B = 2**ADD_WIDTH) can be represented as the byte total.
    localparam int          CNT_W = ADD_WIDTH + 1;
    // Largest instruction count that fits in memory (4 bytes per instruction).
    localparam int unsigned MAX_N = (2 ** ADD_WIDTH) / 4;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [CNT_W-1:0]      total_q,      total_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  wr_en_q,      wr_en_d;
    logic [ADD_WIDTH-1:0]  wr_add_q,     wr_add_d;
    logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic                  hold_q,       hold_d;
    logic                  done_q,       done_d;
`ifdef LOADER_CHECKSUM_EN
    logic                  err_q,        err_d;
    logic [DATA_WIDTH-1:0] xor_q,        xor_d;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    int unsigned      hdr_val;
    int unsigned      hdr_n;

    always_comb begin
        // A byte moves only when we advertised ready this cycle.
        accept  = bus.byte_valid & byte_ready_q;
        cnt_inc = cnt_q + CNT_W'(1);

        // Header 0 means "fill the whole memory"; anything larger than the
        // memory is clamped so the address can never wrap inside a frame.
        hdr_val = 32'(bus.byte_in);
        if ((hdr_val == 0) || (hdr_val > MAX_N)) begin
            hdr_n = MAX_N;
        end else begin
            hdr_n = hdr_val;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        wr_en_d   = 1'b0;            // strobe: one cycle per accepted payload byte
        wr_add_d  = wr_add_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
`ifdef LOADER_CHECKSUM_EN
        err_d     = err_q;
        xor_d     = xor_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // byte_ready is low here, so a concurrent byte_valid is
                // simply not consumed while the start is taken.
                if (load_start) begin
                    state_d  = S_HDR;
                    cnt_d    = '0;
                    wr_add_d = '0;
                    done_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    err_d    = 1'b0;
`endif
                end
            end

            S_HDR: begin
                if (accept) begin
                    total_d = CNT_W'(hdr_n << 2);
                    state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
                    // The header byte is part of the checksum.
                    xor_d   = bus.byte_in;
`endif
                end
            end

            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_add_d  = cnt_q[ADD_WIDTH-1:0];
                    wr_data_d = bus.byte_in;
                    cnt_d     = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ bus.byte_in;
`endif
                    // Last payload byte: leave DATA on the same edge it is written.
                    if (cnt_inc == total_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = (bus.byte_in != xor_q);
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        byte_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (state_d == S_CSUM)
`endif
                    ;

        case (state_d)
            S_IDLE:  hold_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            // A failed checksum keeps the CPU parked on a bad image.
            S_DONE:  hold_d = err_d;
`else
            S_DONE:  hold_d = 1'b0;
`endif
            default: hold_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            total_q      <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_add_q     <= '0;
            wr_data_q    <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_add_q     <= wr_add_d;
            wr_data_q    <= wr_data_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
            err_q        <= err_d;
            xor_q        <= xor_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.byte_ready = byte_ready_q;
    assign bus.wrEn       = wr_en_q;
    assign bus.writeAdd   = wr_add_q;
    assign bus.writeData  = wr_data_q;
    assign cpu_hold       = hold_q;
    assign load_done      = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign load_err       = err_q;
`else
    assign load_err       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random frames against a frame-level model.
// Latency: expects each payload write in the cycle right after the byte's accept edge.
// Backpressure: bench holds byte_valid until byte_ready, with random idle gaps.
module tb_program_loader;

    localparam int DW   = 8;
    localparam int AW   = 7;
    localparam int MAXN = (2 ** AW) / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic load_start = 1'b0;
    logic cpu_hold;
    logic load_done;
    logic load_err;

    program_loader_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus();

    program_loader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Edge counter: at the falling edge after rising edge k it reads k.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed memory writes and the edge each payload byte was accepted on.
    int unsigned wr_add_log[$];
    int unsigned wr_dat_log[$];
    int unsigned wr_cyc_log[$];
    int unsigned acc_cyc[$];

    logic [7:0] payload [128];

    always @(negedge clk) begin
        if (bus.wrEn === 1'b1) begin
            wr_add_log.push_back(32'(bus.writeAdd));
            wr_dat_log.push_back(32'(bus.writeData));
            wr_cyc_log.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_wren"},  32'(bus.wrEn),       32'd0);
        check({tag, "_add"},   32'(bus.writeAdd),   32'd0);
        check({tag, "_data"},  32'(bus.writeData),  32'd0);
        check({tag, "_hold"},  32'(cpu_hold),       32'd0);
        check({tag, "_done"},  32'(load_done),      32'd0);
        check({tag, "_err"},   32'(load_err),       32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit is_data);
        int wait_n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'($urandom);
                // Stray starts mid-frame must be ignored.
                if ($urandom_range(0, 5) == 0) load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        wait_n = 0;
        while ((bus.byte_ready !== 1'b1) && (wait_n < 20)) begin
            @(negedge clk);
            wait_n++;
        end
        if (bus.byte_ready !== 1'b1) begin
            check("ready_timeout", 32'(bus.byte_ready), 32'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            if (is_data) acc_cyc.push_back(cyc);
        end
    endtask

    task automatic start_frame(input bit with_valid);
        wr_add_log.delete();
        wr_dat_log.delete();
        wr_cyc_log.delete();
        acc_cyc.delete();
        load_start = 1'b1;
        if (with_valid) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = 8'h55;
        end
        @(negedge clk);
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
        check("start_ready", 32'(bus.byte_ready), 32'd1);
        check("start_hold",  32'(cpu_hold),       32'd1);
        check("start_done",  32'(load_done),      32'd0);
        check("start_err",   32'(load_err),       32'd0);
        check("start_add",   32'(bus.writeAdd),   32'd0);
    endtask

    // Full frame: header h, payload[0..4N-1], optional checksum (xor ^ flip).
    task automatic run_frame(input logic [7:0] h, input bit gaps, input logic [7:0] flip,
                             input bit start_with_valid);
        int n;
        int b;
        int m;
        logic [7:0] x;
        logic exp_err;
        n = (h == 8'd0) ? MAXN : ((int'(h) > MAXN) ? MAXN : int'(h));
        b = 4 * n;
        start_frame(start_with_valid);
        send_byte(h, gaps, 1'b0);
        x = h;
        for (int i = 0; i < b; i++) begin
            send_byte(payload[i], gaps, 1'b1);
            x = x ^ payload[i];
        end
`ifdef LOADER_CHECKSUM_EN
        check("csum_ready", 32'(bus.byte_ready), 32'd1);
        check("csum_nodone", 32'(load_done), 32'd0);
        send_byte(x ^ flip, gaps, 1'b0);
        exp_err = (flip != 8'd0);
`else
        exp_err = 1'b0;
        if (flip != 8'd0) exp_err = 1'b0;
`endif
        check("end_done",  32'(load_done),      32'd1);
        check("end_err",   32'(load_err),       32'(exp_err));
        check("end_hold",  32'(cpu_hold),       32'(exp_err));
        check("end_ready", 32'(bus.byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("n_writes", 32'(wr_add_log.size()), 32'(b));
        m = (wr_add_log.size() < b) ? wr_add_log.size() : b;
        if (acc_cyc.size() < m) m = acc_cyc.size();
        for (int i = 0; i < m; i++) begin
            check("wr_add",  wr_add_log[i], 32'(i));
            check("wr_data", wr_dat_log[i], 32'(payload[i]));
            check("wr_cyc",  wr_cyc_log[i], acc_cyc[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) payload[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] flip;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;

        // Reset and idle behaviour
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.byte_ready), 32'd0);
            check("idle_wren",  32'(bus.wrEn),       32'd0);
        end
        bus.byte_valid = 1'b0;

        // Single instruction, back-to-back
        payload[0] = 8'h13; payload[1] = 8'h00; payload[2] = 8'h50; payload[3] = 8'h00;
        run_frame(8'h01, 1'b0, 8'h00, 1'b0);

        // Header 0: full memory, data = address
        for (int i = 0; i < 128; i++) payload[i] = 8'(i);
        run_frame(8'h00, 1'b0, 8'h00, 1'b0);

        // Gapped stream with stray starts
        fill_random();
        run_frame(8'h05, 1'b1, 8'h00, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        payload[0] = 8'hAA; payload[1] = 8'h55; payload[2] = 8'h0F; payload[3] = 8'hF0;
        run_frame(8'h01, 1'b0, 8'h00, 1'b0);
        run_frame(8'h01, 1'b0, 8'h03, 1'b0);
`endif

        // Reset in the middle of DATA
        start_frame(1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst_nwr", 32'(wr_add_log.size()), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        run_frame(8'h02, 1'b0, 8'h00, 1'b0);

        // Start coincident with byte_valid: the byte must not become the header
        fill_random();
        run_frame(8'h03, 1'b0, 8'h00, 1'b1);

        // Random frames, including oversize headers
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 3))
                0:       h = 8'h00;
                1:       h = 8'($urandom_range(33, 255));
                default: h = 8'($urandom_range(1, 32));
            endcase
            flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fill_random();
            run_frame(h, 1'($urandom_range(0, 1)), flip, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
